// File: rtl/logger_pkg.sv
// Shared types and default widths for the logger event capture stage.
package logger_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TS_W_DEF   = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int DROP_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } cap_state_e;

  // Record layout at the default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic                  lost;
    logic [TS_W_DEF-1:0]   ts;
    logic [DATA_W_DEF-1:0] data;
  } logger_rec_t;

endpackage

// File: rtl/logger_sync_fifo.sv
// Single-clock FIFO of records; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate counter.
module logger_sync_fifo
  import logger_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type rec_t = logger_rec_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rec_t                     push_rec,
  input  logic                     pop,
  output rec_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == FULL_CNT);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer advance; the caller only pushes when there is room (or a
  // simultaneous pop) and only pops when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates the outputs.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_rec;
  end

endmodule

// File: rtl/logger_event_capture.sv
// Watches a bus for masked value changes, timestamps each change and queues
// it for the logger. Drops on a full queue are counted and flagged on the
// next record that makes it in.
module logger_event_capture
  import logger_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [DATA_W-1:0]        sig_in,
  input  logic [DATA_W-1:0]        sig_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_lost,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_stat
);

  typedef struct packed {
    logic              lost;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } rec_t;

  cap_state_e        state;
  logic [TS_W-1:0]   ts_cnt;
  logic [DATA_W-1:0] prev_val;
  logic              pending_lost;

  rec_t push_rec;
  rec_t head;
  logic full, empty;
  logic changed, push_req, pop, accept, drop;

  // Capture decision for this cycle; a full queue still takes the record
  // when the consumer frees a slot at the same edge.
  always_comb begin
    changed  = |((sig_in ^ prev_val) & sig_mask);
    push_req = (state == ARM) || ((state == RUN) && changed);
    pop      = !empty && out_ready;
    accept   = push_req && (!full || pop);
    drop     = push_req && !accept;
    push_rec = '{lost: pending_lost, ts: ts_cnt, data: sig_in};
  end

  logger_sync_fifo #(
    .DEPTH (DEPTH),
    .rec_t (rec_t)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .push_rec (push_rec),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fill)
  );

  // Head of queue is presented only while valid so stale storage never leaks.
  assign out_valid = !empty;
  assign out_ts    = empty ? '0 : head.ts;
  assign out_data  = empty ? '0 : head.data;
  assign out_lost  = empty ? 1'b0 : head.lost;

  // Free-running timestamp, wraps silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + 1'b1;
  end

  // Capture FSM: ARM takes a baseline and primes prev_val, RUN tracks changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      prev_val <= '0;
    end else begin
      case (state)
        IDLE: if (en) state <= ARM;
        ARM: begin
          prev_val <= sig_in;
          state    <= en ? RUN : IDLE;
        end
        RUN: begin
          prev_val <= sig_in;
          if (!en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drop bookkeeping; a drop in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_lost <= 1'b0;
      overflow     <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      if (accept)    pending_lost <= 1'b0;
      else if (drop) pending_lost <= 1'b1;

      if (drop) begin
        overflow <= 1'b1;
        if (clr_stat)            drop_cnt <= DROP_W'(1);
        else if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end else if (clr_stat) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_logger_event_capture.sv
// Randomised bench for logger_event_capture with a queue-based reference model.
module tb_logger_event_capture;

  localparam int DATA_W = 32;
  localparam int TS_W   = 4;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 4;
  localparam int DROP_MAX = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [DATA_W-1:0] sig_in;
  logic [DATA_W-1:0] sig_mask;
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ts;
  logic [DATA_W-1:0] out_data;
  logic              out_lost;
  logic [4:0]        fill;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              clr_stat;

  logger_event_capture #(
    .DATA_W (DATA_W), .TS_W (TS_W), .DEPTH (DEPTH), .DROP_W (DROP_W)
  ) dut (
    .clk (clk), .rst (rst), .en (en), .sig_in (sig_in), .sig_mask (sig_mask),
    .out_valid (out_valid), .out_ready (out_ready), .out_ts (out_ts),
    .out_data (out_data), .out_lost (out_lost), .fill (fill),
    .overflow (overflow), .drop_cnt (drop_cnt), .clr_stat (clr_stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              lost;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } mrec_t;

  // Reference model state
  mrec_t       mq[$];
  int          m_mode;      // 0 idle, 1 baseline due, 2 tracking
  logic [31:0] m_prev;
  logic        m_pend;
  int          m_drops;
  logic        m_ovf;
  int          m_ts;

  // Records the DUT actually handed over
  mrec_t obs_q[$];

  int vectors    = 0;
  int miscompares = 0;
  logic [31:0] cur;

  task automatic mdl_reset();
    mq.delete();
    m_mode = 0; m_prev = '0; m_pend = 1'b0;
    m_drops = 0; m_ovf = 1'b0; m_ts = 0;
  endtask

  function automatic logic [47:0] exp_vec();
    logic v;
    mrec_t h;
    v = (mq.size() > 0);
    h = '{1'b0, 4'd0, 32'd0};
    if (v) h = mq[0];
    return {v, h.ts, h.data, h.lost, 5'(mq.size()), m_ovf, 4'(m_drops)};
  endfunction

  function automatic logic [47:0] obs_vec();
    return {out_valid, out_ts, out_data, out_lost, fill, overflow, drop_cnt};
  endfunction

  // One clock of stimulus; the model advances by the rules at the same edge.
  task automatic step(input logic e, input logic [31:0] s, input logic [31:0] mk,
                      input logic r, input logic c);
    logic pop, want, room, dropped;
    en = e; sig_in = s; sig_mask = mk; out_ready = r; clr_stat = c;
    #1;
    if (out_valid && r) obs_q.push_back('{out_lost, out_ts, out_data});
    @(posedge clk);
    pop  = (mq.size() > 0) && r;
    want = (m_mode == 1) || (m_mode == 2 && ((s ^ m_prev) & mk) != 0);
    room = (mq.size() < DEPTH) || pop;
    dropped = 1'b0;
    if (pop) void'(mq.pop_front());
    if (want && room) begin
      mq.push_back('{m_pend, 4'(m_ts), s});
      m_pend = 1'b0;
    end else if (want) begin
      dropped = 1'b1;
      m_pend  = 1'b1;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_drops = c ? 1 : ((m_drops < DROP_MAX) ? m_drops + 1 : DROP_MAX);
    end else if (c) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    if (m_mode != 0) m_prev = s;
    m_mode = (m_mode == 0) ? (e ? 1 : 0) : (e ? 2 : 0);
    m_ts = (m_ts + 1) % 16;
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (obs_vec() !== 48'd0) begin
      miscompares++;
      $display("FAIL reset_state got %h want %h", obs_vec(), 48'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic test_baseline();
    int n0;
    n0 = obs_q.size();
    cur = 32'h5;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, cur, '1, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL baseline cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (obs_q.size() - n0 !== 1) begin
      miscompares++;
      $display("FAIL baseline_count got %0d want 1", obs_q.size() - n0);
    end else begin
      vectors++;
      if ({obs_q[n0].lost, obs_q[n0].ts, obs_q[n0].data} !== {1'b0, 4'd1, 32'h5}) begin
        miscompares++;
        $display("FAIL baseline_rec got %b/%0d/%h want 0/1/5",
                 obs_q[n0].lost, obs_q[n0].ts, obs_q[n0].data);
      end
    end
  endtask

  task automatic test_changes();
    logic [31:0] seq [6];
    int n0;
    seq = '{32'h7, 32'h7, 32'h4, 32'h4, 32'h4, 32'h4};
    n0 = obs_q.size();
    for (int i = 0; i < 6; i++) begin
      cur = seq[i];
      step(1'b1, cur, '1, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec() || fill > 1) begin
        miscompares++;
        $display("FAIL changes cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (obs_q.size() - n0 !== 2) begin
      miscompares++;
      $display("FAIL changes_count got %0d want 2", obs_q.size() - n0);
    end else begin
      vectors++;
      if (obs_q[n0].data !== 32'h7 || obs_q[n0+1].data !== 32'h4 ||
          4'(obs_q[n0+1].ts - obs_q[n0].ts) !== 4'd2) begin
        miscompares++;
        $display("FAIL changes_recs got %h@%0d %h@%0d want 7 then 4 two ticks later",
                 obs_q[n0].data, obs_q[n0].ts, obs_q[n0+1].data, obs_q[n0+1].ts);
      end
    end
  endtask

  task automatic test_mask();
    int n0;
    n0 = obs_q.size();
    for (int i = 0; i < 6; i++) begin
      cur = cur ^ 32'h1;
      step(1'b1, cur, 32'hFFFF_FFFE, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL mask_bit0 cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (obs_q.size() !== n0) begin
      miscompares++;
      $display("FAIL mask_quiet got %0d records want 0", obs_q.size() - n0);
    end
    cur = cur ^ 32'h10 ^ ($urandom & 32'hFFFF_0001);
    step(1'b1, cur, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(1'b1, cur, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(1'b1, cur, 32'hFFFF_FFFE, 1'b1, 1'b0);
    vectors++;
    if (obs_q.size() - n0 !== 1 || obs_q[obs_q.size()-1].data !== cur) begin
      miscompares++;
      $display("FAIL mask_bit4 got %0d records last %h want 1 record %h",
               obs_q.size() - n0, obs_q[obs_q.size()-1].data, cur);
    end
  endtask

  task automatic test_overflow();
    int n0, lost_early;
    step(1'b0, cur, '1, 1'b0, 1'b0);
    step(1'b1, cur, '1, 1'b0, 1'b0);
    step(1'b1, cur, '1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cur = cur ^ ($urandom | 32'h1);
      step(1'b1, cur, '1, 1'b0, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL overflow_fill cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (fill !== 5'd16 || drop_cnt !== 4'd5 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_stats got fill=%0d drops=%0d ovf=%b want 16/5/1",
               fill, drop_cnt, overflow);
    end
    n0 = obs_q.size();
    for (int i = 0; i < 16; i++) step(1'b1, cur, '1, 1'b1, 1'b0);
    cur = cur ^ 32'h100;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, cur, '1, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL overflow_drain cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    lost_early = 0;
    for (int i = n0; i < obs_q.size() - 1; i++) lost_early += int'(obs_q[i].lost);
    vectors++;
    if (obs_q.size() - n0 !== 17 || lost_early !== 0 ||
        obs_q[obs_q.size()-1].lost !== 1'b1 || obs_q[obs_q.size()-1].data !== cur) begin
      miscompares++;
      $display("FAIL overflow_lost got %0d records early_lost=%0d last lost=%b want 17/0/1",
               obs_q.size() - n0, lost_early, obs_q[obs_q.size()-1].lost);
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) begin
      cur = cur ^ ($urandom | 32'h2);
      step(1'b1, cur, '1, 1'b0, 1'b0);
    end
    cur = cur ^ 32'h8000_0000;
    step(1'b1, cur, '1, 1'b1, 1'b0);
    vectors++;
    if (fill !== 5'd16 || drop_cnt !== 4'd5 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL full_pop got fill=%0d drops=%0d vec %h want 16/5 vec %h",
               fill, drop_cnt, obs_vec(), exp_vec());
    end
  endtask

  task automatic test_sat_clear();
    cur = cur ^ 32'h3;
    step(1'b1, cur, '1, 1'b0, 1'b1);
    vectors++;
    if (drop_cnt !== 4'd1 || overflow !== 1'b1 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL clr_with_drop got drops=%0d ovf=%b want 1/1", drop_cnt, overflow);
    end
    step(1'b1, cur, '1, 1'b0, 1'b1);
    vectors++;
    if (drop_cnt !== 4'd0 || overflow !== 1'b0 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL clr_alone got drops=%0d ovf=%b want 0/0", drop_cnt, overflow);
    end
    for (int i = 0; i < 20; i++) begin
      cur = cur ^ ($urandom | 32'h4);
      step(1'b1, cur, '1, 1'b0, 1'b0);
    end
    vectors++;
    if (drop_cnt !== 4'd15 || obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL drop_saturate got drops=%0d want 15", drop_cnt);
    end
    for (int i = 0; i < 20; i++) step(1'b1, cur, '1, 1'b1, i == 0);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL sat_drain got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic [31:0] masks [4];
    logic [31:0] mk;
    masks = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_000F, 32'h00F0_0F00};
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) cur = cur ^ ($urandom & 32'h00FF_0FFF);
      mk = masks[$urandom_range(0, 3)];
      step($urandom_range(0, 7) != 0, cur, mk, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrap_reset();
    int n0;
    bit seen;
    for (int i = 0; i < 10; i++) step(1'b1, cur, '1, 1'b1, 1'b1);
    n0 = obs_q.size();
    for (int i = 0; i < 20; i++) begin
      cur = cur ^ ($urandom | 32'h1);
      step(1'b1, cur, '1, 1'b1, 1'b0);
    end
    seen = 1'b0;
    for (int i = n0; i < obs_q.size() - 1; i++)
      if (obs_q[i].ts == 4'd15 && obs_q[i+1].ts == 4'd0) seen = 1'b1;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL ts_wrap got no 15->0 pair in %0d records want one",
               obs_q.size() - n0);
    end
    for (int i = 0; i < 5; i++) begin
      cur = cur ^ 32'h40;
      step(1'b1, cur, '1, 1'b0, 1'b0);
    end
    #3;
    rst = 1'b1;
    mdl_reset();
    #1;
    vectors++;
    if (obs_vec() !== 48'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0", obs_vec());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, cur, '1, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL post_reset_idle cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, cur, '1, 1'b0, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL post_reset_arm cyc%0d got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sig_in = '0; sig_mask = '0; out_ready = 1'b0; clr_stat = 1'b0;
    cur = '0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_baseline();
    test_changes();
    test_mask();
    test_overflow();
    test_full_pop();
    test_sat_clear();
    test_random();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
